// File: rtl/mac_acc_collector.sv
// mac_acc_collector
//   Job controller and result FIFO wrapped around a single MAC datapath.
//   A job (len, init_val, mode) gates the MAC enable for exactly len
//   accepted operand beats. Once the MAC pipeline has settled, the
//   accumulated C is captured and queued for a valid/ready consumer.
// Ports
//   clk, rst             : clock, asynchronous active-low reset
//   start/len/init_val/mode : job request, sampled only while idle
//   in_valid / in_ready  : operand beat handshake (MAC A/B driven upstream)
//   mac_en/mac_load/mac_cfg : MAC control; mac_c is the MAC result
//   out_valid/out_data/out_ready : result FIFO head and consumer pop
//   busy                 : a job is in flight (state not IDLE)
module mac_acc_collector #(
   parameter int ACC_WIDTH  = 32,
   parameter int CONF_WIDTH = 3,
   parameter int LEN_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [LEN_WIDTH-1:0]            len,
   input  logic [ACC_WIDTH-1:0]            init_val,
   input  logic [1:0]                      mode,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic                            mac_en,
   output logic                            mac_load,
   output logic [ACC_WIDTH+CONF_WIDTH-1:0] mac_cfg,
   input  logic [ACC_WIDTH-1:0]            mac_c,
   output logic                            out_valid,
   output logic [ACC_WIDTH-1:0]            out_data,
   input  logic                            out_ready,
   output logic                            busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HOLD} state_t;
   state_t state_q, state_d;

   logic [LEN_WIDTH-1:0] len_q, len_d, remaining_q, remaining_d;
   logic [ACC_WIDTH-1:0] init_val_q, init_val_d, hold_q, hold_d;
   logic [1:0]           mode_q, mode_d;
   // Accumulate bit of the MAC config is held as a flop so mac_cfg reads 0
   // out of reset and only becomes {init,1,mode} once a job is accepted.
   logic                 cfg_acc_q, cfg_acc_d;
   logic                 bypass_q, bypass_d;

   logic [ACC_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [ACC_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic                 accept, fifo_full, push, pop;
   logic [ACC_WIDTH-1:0] drain_res, push_data;
   logic [CONF_WIDTH-1:0] conf;

   assign accept    = (state_q == S_IDLE) && start;
   // Full is judged on the registered count: a same-cycle pop does not
   // make room for a push until the next cycle.
   assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
   assign drain_res = bypass_q ? init_val_q : mac_c;
   assign push      = ((state_q == S_DRAIN) || (state_q == S_HOLD)) && !fifo_full;
   assign push_data = (state_q == S_HOLD) ? hold_q : drain_res;
   assign pop       = out_ready && (count_q != '0);

   // State register and datapath flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         remaining_q <= '0;
         init_val_q  <= '0;
         mode_q      <= '0;
         cfg_acc_q   <= 1'b0;
         bypass_q    <= 1'b0;
         hold_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         remaining_q <= remaining_d;
         init_val_q  <= init_val_d;
         mode_q      <= mode_d;
         cfg_acc_q   <= cfg_acc_d;
         bypass_q    <= bypass_d;
         hold_q      <= hold_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mem_q       <= mem_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (len == '0) ? S_DRAIN : S_RUN;
         S_RUN:   if (mac_en && (remaining_q == LEN_WIDTH'(1))) state_d = S_DRAIN;
         S_DRAIN: state_d = fifo_full ? S_HOLD : S_IDLE;
         S_HOLD:  if (!fifo_full) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      conf      = '0;
      conf[2]   = cfg_acc_q;
      conf[1:0] = mode_q;
      in_ready  = (state_q == S_RUN);
      mac_en    = in_valid && in_ready;
      mac_load  = mac_en && (remaining_q == len_q);
      mac_cfg   = {init_val_q, conf};
      busy      = (state_q != S_IDLE);
      out_valid = (count_q != '0);
      out_data  = mem_q[rd_ptr_q];
   end

   // Job fields, beat counter and result capture
   always_comb begin
      len_d       = len_q;
      init_val_d  = init_val_q;
      mode_d      = mode_q;
      cfg_acc_d   = cfg_acc_q;
      bypass_d    = bypass_q;
      remaining_d = remaining_q;
      hold_d      = hold_q;
      if (accept) begin
         len_d       = len;
         init_val_d  = init_val;
         mode_d      = mode;
         cfg_acc_d   = 1'b1;
         bypass_d    = (len == '0);
         remaining_d = len;
      end
      if (mac_en) remaining_d = remaining_q - LEN_WIDTH'(1);
      if ((state_q == S_DRAIN) && fifo_full) hold_d = drain_res;
   end

   // Result FIFO: circular buffer, pointers wrap on the power-of-two depth
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

endmodule

// File: tb/tb_mac_acc_collector.sv
module tb_mac_acc_collector;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic [31:0] init_val = '0;
   logic [1:0]  mode = '0;
   logic        in_valid = 1'b0;
   logic        in_ready, mac_en, mac_load;
   logic [34:0] mac_cfg;
   logic [31:0] mac_c;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready = 1'b0;
   logic        busy;

   logic [31:0] prod = '0;
   logic [31:0] acc_m = '0;
   logic        toggle_en = 1'b0;
   int          n_tests = 0, n_fail = 0;
   int          en_cnt = 0, load_cnt = 0;
   logic [31:0] exp_q[$];

   mac_acc_collector dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .init_val(init_val),
      .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .mac_en(mac_en),
      .mac_load(mac_load), .mac_cfg(mac_cfg), .mac_c(mac_c),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural MAC: C = (load ? init : C) + product, registered
   always_ff @(posedge clk) if (mac_en) acc_m <= (mac_load ? mac_cfg[34:3] : acc_m) + prod;
   assign mac_c = acc_m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (mac_en) en_cnt++;
      if (mac_load) load_cnt++;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_extra: got %0h expected no result", out_data);
         end else begin
            chk("sb_data", {32'd0, out_data}, {32'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (toggle_en) out_ready = ~out_ready;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 40) begin tick(); k++; end
      chk(name, {63'd0, busy}, 64'd0);
   endtask

   task automatic settle(input string name);
      for (int k = 0; k < 8; k++) tick();
      chk(name, exp_q.size(), 0);
   endtask

   // Issue a job with products p0, p0+1, ... and a hand-computed result
   task automatic job(input int n, input logic [31:0] iv, input logic [31:0] p0,
                      input logic [31:0] expv);
      exp_q.push_back(expv);
      start = 1'b1; len = 8'(n); init_val = iv; mode = 2'd0;
      tick();
      start = 1'b0;
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b1; prod = p0 + 32'(k);
         tick();
      end
      in_valid = 1'b0;
   endtask

   typedef struct { int n; logic [31:0] iv; logic [31:0] p0; logic [31:0] ex; } vec_t;
   vec_t wrap_tbl[10] = '{
      '{1, 32'd1000, 32'd1,  32'd1001},
      '{2, 32'd2000, 32'd5,  32'd2011},
      '{1, 32'd3000, 32'd3,  32'd3003},
      '{3, 32'd4000, 32'd1,  32'd4006},
      '{1, 32'd5000, 32'd7,  32'd5007},
      '{2, 32'd6000, 32'd10, 32'd6021},
      '{1, 32'd7000, 32'd2,  32'd7002},
      '{0, 32'd8000, 32'd0,  32'd8000},
      '{1, 32'd9000, 32'd9,  32'd9009},
      '{2, 32'hFFFF_FFFF, 32'd1, 32'd2}
   };

   initial begin
      int e0, l0, pi;
      logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      // Reset state
      #12;
      chk("rst_in_ready", {63'd0, in_ready}, 0);
      chk("rst_mac_en", {63'd0, mac_en}, 0);
      chk("rst_mac_load", {63'd0, mac_load}, 0);
      chk("rst_out_valid", {63'd0, out_valid}, 0);
      chk("rst_busy", {63'd0, busy}, 0);
      chk("rst_mac_cfg", {29'd0, mac_cfg}, 0);
      chk("rst_out_data", {32'd0, out_data}, 0);
      @(negedge clk); rst = 1'b1;
      tick();

      // Single job: 10 + 2 + 3 + 4 = 19
      out_ready = 1'b1;
      e0 = en_cnt; l0 = load_cnt;
      exp_q.push_back(32'd19);
      start = 1'b1; len = 8'd3; init_val = 32'd10; mode = 2'd0;
      tick();
      start = 1'b0;
      chk("t1_busy", {63'd0, busy}, 1);
      chk("t1_in_ready", {63'd0, in_ready}, 1);
      chk("t1_cfg", {29'd0, mac_cfg}, {29'd0, 32'd10, 3'b100});
      in_valid = 1'b1; prod = 32'd2; tick();
      prod = 32'd3; tick();
      prod = 32'd4; tick();
      in_valid = 1'b0;
      chk("t1_ov_early", {63'd0, out_valid}, 0);
      chk("t1_drain_busy", {63'd0, busy}, 1);
      tick();
      chk("t1_ov_latency", {63'd0, out_valid}, 1);
      chk("t1_out_data", {32'd0, out_data}, 64'd19);
      wait_idle("t1_idle");
      settle("t1_sb_empty");
      chk("t1_en_cnt", en_cnt - e0, 3);
      chk("t1_load_cnt", load_cnt - l0, 1);
      chk("t1_cfg_stable", {29'd0, mac_cfg}, {29'd0, 32'd10, 3'b100});

      // Stalls: 100 + 1 + 2 + 3 + 4 = 110
      e0 = en_cnt; l0 = load_cnt;
      exp_q.push_back(32'd110);
      start = 1'b1; len = 8'd4; init_val = 32'd100;
      tick();
      start = 1'b0;
      pi = 1;
      for (int i = 0; i < 7; i++) begin
         in_valid = pat[i];
         prod = pat[i] ? 32'(pi) : 32'd0;
         if (pat[i]) pi++;
         tick();
      end
      in_valid = 1'b0;
      wait_idle("t2_idle");
      settle("t2_sb_empty");
      chk("t2_en_cnt", en_cnt - e0, 4);
      chk("t2_load_cnt", load_cnt - l0, 1);

      // Zero length: bypass, MAC untouched
      e0 = en_cnt;
      exp_q.push_back(32'hDEAD_BEEF);
      start = 1'b1; len = 8'd0; init_val = 32'hDEAD_BEEF; mode = 2'd2;
      tick();
      start = 1'b0;
      chk("t3_in_ready", {63'd0, in_ready}, 0);
      chk("t3_busy", {63'd0, busy}, 1);
      chk("t3_cfg", {29'd0, mac_cfg}, {29'd0, 32'hDEAD_BEEF, 3'b110});
      tick();
      chk("t3_ov", {63'd0, out_valid}, 1);
      chk("t3_out_data", {32'd0, out_data}, {32'd0, 32'hDEAD_BEEF});
      wait_idle("t3_idle");
      settle("t3_sb_empty");
      chk("t3_en_cnt", en_cnt - e0, 0);

      // FIFO full and HOLD
      out_ready = 1'b0;
      job(1, 32'h100, 32'd1, 32'h101); wait_idle("t4_idle0");
      job(1, 32'h200, 32'd2, 32'h202); wait_idle("t4_idle1");
      job(1, 32'h300, 32'd3, 32'h303); wait_idle("t4_idle2");
      job(1, 32'h400, 32'd4, 32'h404); wait_idle("t4_idle3");
      job(1, 32'h500, 32'd5, 32'h505);
      tick();
      chk("t4_hold_busy", {63'd0, busy}, 1);
      chk("t4_hold_ready", {63'd0, in_ready}, 0);
      start = 1'b1; len = 8'd1; init_val = 32'h999;
      tick();
      start = 1'b0;
      chk("t4_ignored_busy", {63'd0, busy}, 1);
      chk("t4_cfg_stable", {32'd0, mac_cfg[34:3]}, {32'd0, 32'h500});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t4_still_hold", {63'd0, busy}, 1);
      tick();
      chk("t4_hold_done", {63'd0, busy}, 0);
      tick(); tick();
      chk("t4_no_queued_start", {63'd0, busy}, 0);
      out_ready = 1'b1;
      settle("t4_sb_empty");

      // Wrap-around with toggling consumer
      out_ready = 1'b0;
      toggle_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         job(wrap_tbl[i].n, wrap_tbl[i].iv, wrap_tbl[i].p0, wrap_tbl[i].ex);
         wait_idle("t5_idle");
      end
      toggle_en = 1'b0;
      tick();
      out_ready = 1'b1;
      settle("t5_sb_empty");

      // Reset mid-job with two results queued
      out_ready = 1'b0;
      job(1, 32'h10, 32'd1, 32'h11); wait_idle("t6_idle0");
      job(1, 32'h20, 32'd2, 32'h22); wait_idle("t6_idle1");
      chk("t6_pre_ov", {63'd0, out_valid}, 1);
      start = 1'b1; len = 8'd4; init_val = 32'h40;
      tick();
      start = 1'b0;
      in_valid = 1'b1; prod = 32'd1; tick();
      prod = 32'd2; tick();
      chk("t6_pre_busy", {63'd0, busy}, 1);
      rst = 1'b0;
      #1;
      chk("t6_in_ready", {63'd0, in_ready}, 0);
      chk("t6_mac_en", {63'd0, mac_en}, 0);
      chk("t6_mac_load", {63'd0, mac_load}, 0);
      chk("t6_out_valid", {63'd0, out_valid}, 0);
      chk("t6_busy", {63'd0, busy}, 0);
      chk("t6_mac_cfg", {29'd0, mac_cfg}, 0);
      chk("t6_out_data", {32'd0, out_data}, 0);
      exp_q.delete();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("t6_post_busy", {63'd0, busy}, 0);
      out_ready = 1'b1;
      job(1, 32'd50, 32'd7, 32'd57);
      wait_idle("t6_idle2");
      settle("t6_sb_empty");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_acc_collector.md
# mac_acc_collector

Job controller and result buffer sitting directly downstream of (and wrapped around) a single MAC block. It accepts a job (length, initial accumulator value, precision mode), gates the MAC's `en` for exactly `len` accepted operand beats, captures the accumulated `C` once the MAC pipeline has settled, and queues results in a small FIFO drained by a valid/ready consumer. The MAC itself stays purely datapath; all sequencing lives here.

## Interface

**Parameters**
- `ACC_WIDTH`, 32: accumulator/result width; equals the MAC accumulator width.
- `CONF_WIDTH`, 3: MAC config field width; bit 2 selects accumulate, bits 1:0 select the mode.
- `LEN_WIDTH`, 8: job length counter width.
- `FIFO_DEPTH`, 4: result FIFO entries; must be a power of two, at least 2.

**Ports**
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: job request; sampled only in IDLE.
- `len`  in  LEN_WIDTH: number of products to accumulate; latched on accepted `start`.
- `init_val`  in  ACC_WIDTH: starting accumulator value; latched on accepted `start`.
- `mode`  in  2: 0 = single, 1 = dual, 2 = quad; latched on accepted `start`.
- `in_valid`  in  1: upstream operand beat present on the MAC A/B inputs.
- `in_ready`  out  1: collector accepts beats (state RUN).
- `mac_en`  out  1: MAC accumulate enable, equal to `in_valid & in_ready`.
- `mac_load`  out  1: high with the first `mac_en` of a job; the MAC computes `init + product` instead of `acc + product`.
- `mac_cfg`  out  ACC_WIDTH+CONF_WIDTH: `{init_val_q, 1'b1, mode_q}`; stable for the whole job.
- `mac_c`  in  ACC_WIDTH: MAC result `C`.
- `out_valid`  out  1: FIFO non-empty.
- `out_data`  out  ACC_WIDTH: FIFO head.
- `out_ready`  in  1: consumer pop.
- `busy`  out  1: state is not IDLE.

## Operation

- **States:** IDLE, RUN, DRAIN, HOLD.
- **IDLE**
  - `start=1` and `len!=0`: latch `len`, `init_val` and `mode`, load `remaining=len`, go to RUN.
  - `start=1` and `len=0`: latch the inputs; the result is `init_val` itself (bypass, MAC untouched). Go to DRAIN with the bypass flag set.
- **RUN**
  - `in_ready=1`.
  - Each beat with `in_valid=1` decrements `remaining`.
  - `mac_load` is high on the first beat only (`remaining==len_q`).
  - On the beat where `remaining==1`, go to DRAIN.
  - Cycles with `in_valid=0` are stalls: no count change, `mac_en=0`.
- **DRAIN**
  - Result = bypass ? `init_val_q` : `mac_c`.
  - If FIFO count < FIFO_DEPTH, write the result and go to IDLE.
  - Otherwise capture the result into `hold_q` and go to HOLD.
- **HOLD**
  - Write `hold_q` when count < FIFO_DEPTH, then go to IDLE.
  - A pop in the same cycle does not free space until the next cycle; there is no full-FIFO pass-through.
- **Ignored requests:** `start` in any state other than IDLE is ignored and is not queued.
- **FIFO**
  - Circular buffer with a count register.
  - Push and pop in the same cycle (non-empty, non-full) leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **Arithmetic:** none inside this block. Results are stored unmodified; MAC overflow wraps mod 2^ACC_WIDTH upstream.
- **Reset** (asynchronous, any state including mid-job or mid-HOLD):
  - State goes to IDLE; FIFO is emptied; all latched fields are cleared to 0.
  - Any in-flight job is discarded.

## Timing

- **Reset values:**
  - `in_ready`, `mac_en`, `mac_load`, `out_valid`, `busy` = 0.
  - `mac_cfg` = 0, `out_data` = 0.
- **Start:** `start` accepted at edge 0. `busy=1` and `in_ready=1` from cycle 1.
- **Contract with the MAC:** `mac_c` is valid in the cycle after the last `mac_en` beat. With the last beat at edge t, DRAIN occupies cycle t+1 and samples `mac_c`.
- **Result latency:**
  - FIFO write at edge t+2; `out_valid=1` from cycle t+2.
  - With no stalls and `len=N`: `start` at edge 0 gives `out_valid` at edge N+2.
- **`len=0`:** `start` at edge 0, DRAIN in cycle 1, `out_valid` at edge 2.
- **Back-to-back jobs:** the earliest next `start` is accepted in the IDLE cycle after DRAIN or HOLD, giving a minimum job gap of one IDLE cycle.
- **Stability:** `mac_cfg` changes only at the edge that accepts `start`.

## Test plan

- **Single job:** reset; `start` with len=3, init=10, mode=0; beats with products 2, 3, 4, MAC model returning 19 → exactly three `mac_en` pulses, `mac_load` on the first only, `out_data=19`, `out_valid` rising 5 cycles after `start`.
- **Stalls:** len=4 with `in_valid` pattern 1,0,0,1,1,0,1 → exactly 4 `mac_en`; `remaining` holds during gaps; one result pushed.
- **Zero length:** len=0, init=0xDEADBEEF → no `mac_en`; `out_data=0xDEADBEEF` at edge 2.
- **FIFO full and HOLD:** `out_ready=0`; run 5 jobs of len=1 → after 4 results, the 5th job sits in HOLD with `busy=1` and `start` ignored. Raise `out_ready` for one cycle → 5th result written the following cycle. Drain → results appear in FIFO order.
- **Wrap-around and concurrency:** run 10 jobs with `out_ready` toggling 1,0,… → every result appears exactly once, in order; pointers wrap; simultaneous push/pop keeps the count correct.
- **Reset mid-job:** assert `rst` low during RUN with 2 beats remaining and 2 results in the FIFO → all outputs 0 immediately (asynchronous). After release, a new len=1 job completes normally with `out_data` equal to its own result only.
